// File: rtl/perf_cnt_pkg.sv
// Shared definitions for the performance counter bank: readout state
// encoding and the select-width helper used to size channel indices.
package perf_cnt_pkg;

   typedef enum logic [0:0] {
      RD_MANUAL = 1'b0,
      RD_AUTO   = 1'b1
   } rd_state_e;

   // Width needed to index n items, never less than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/perf_cnt_channel.sv
// One performance counter channel: live counter, sticky overflow flag and
// snapshot shadow register.
// Optional build macro PERF_CNT_SAT_EN: when defined the counter saturates
// at all-ones instead of wrapping to zero.
module perf_cnt_channel #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   input  logic             snap,
   output logic [CNT_W-1:0] shadow,
   output logic             ovf
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             ovf_nxt_s;
   logic             at_max_s;

   assign at_max_s = &cnt_r;

   // Next counter and overflow value: clear wins over increment.
   always_comb begin
      cnt_nxt_s = cnt_r;
      ovf_nxt_s = ovf;
      if (clr) begin
         cnt_nxt_s = '0;
         ovf_nxt_s = 1'b0;
      end else if (inc) begin
         if (at_max_s) begin
            ovf_nxt_s = 1'b1;
`ifdef PERF_CNT_SAT_EN
            cnt_nxt_s = cnt_r;
`else
            cnt_nxt_s = '0;
`endif
         end else begin
            cnt_nxt_s = cnt_r + ONE;
         end
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Counter and overflow registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= '0;
         ovf   <= 1'b0;
      end else begin
         cnt_r <= cnt_nxt_s;
         ovf   <= ovf_nxt_s;
      end
   end

   // Shadow captures the pre-edge counter on snap; clear never touches it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow <= '0;
      end else if (snap) begin
         shadow <= cnt_r;
      end else begin
         shadow <= shadow;
      end
   end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH gated event counters with atomic snapshot and a readout
// port that shows one shadow register at a time, either selected manually
// or rotated automatically every DWELL cycles.
// Optional build macro PERF_CNT_SAT_EN (see perf_cnt_channel): saturating
// counters instead of wrapping counters.
module perf_counter_bank
   import perf_cnt_pkg::*;
#(
   parameter  int NUM_CH = 8,
   parameter  int CNT_W  = 32,
   parameter  int DWELL  = 4,
   localparam int SEL_W  = clog2_min1(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [NUM_CH-1:0] evt,
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic              clr,
   input  logic              snap,
   input  logic              auto_rot,
   input  logic [SEL_W-1:0]  sel,
   output logic [SEL_W-1:0]  rd_ch,
   output logic [CNT_W-1:0]  rd_data,
   output logic [NUM_CH-1:0] ovf
);

   localparam int               DW_W    = clog2_min1(DWELL);
   localparam logic [DW_W-1:0]  DW_LAST = DW_W'(DWELL - 1);
   localparam logic [DW_W-1:0]  DW_ONE  = DW_W'(1);
   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);
   localparam logic [SEL_W-1:0] CH_ONE  = SEL_W'(1);

   logic [NUM_CH-1:0] inc_s;
   logic [CNT_W-1:0]  shadow_s [NUM_CH];
   logic [CNT_W-1:0]  rd_sel_s;

   rd_state_e         state_r;
   rd_state_e         state_nxt_s;
   logic [DW_W-1:0]   dwell_r;
   logic [DW_W-1:0]   dwell_nxt_s;
   logic [SEL_W-1:0]  rd_ch_nxt_s;

   assign inc_s = {NUM_CH{en}} & ch_mask & evt;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      perf_cnt_channel #(
         .CNT_W (CNT_W)
      ) u_ch (
         .clk    (clk),
         .rst    (rst),
         .inc    (inc_s[i]),
         .clr    (clr),
         .snap   (snap),
         .shadow (shadow_s[i]),
         .ovf    (ovf[i])
      );
   end

   // Readout FSM next state: manual follows sel, auto steps after DWELL cycles.
   always_comb begin
      state_nxt_s = state_r;
      dwell_nxt_s = dwell_r;
      rd_ch_nxt_s = rd_ch;
      case (state_r)
         RD_MANUAL: begin
            if (auto_rot) begin
               state_nxt_s = RD_AUTO;
               dwell_nxt_s = '0;
            end else begin
               rd_ch_nxt_s = sel;
               dwell_nxt_s = '0;
            end
         end
         RD_AUTO: begin
            if (!auto_rot) begin
               state_nxt_s = RD_MANUAL;
               rd_ch_nxt_s = sel;
               dwell_nxt_s = '0;
            end else if (dwell_r == DW_LAST) begin
               dwell_nxt_s = '0;
               rd_ch_nxt_s = (rd_ch == LAST_CH) ? '0 : rd_ch + CH_ONE;
            end else begin
               dwell_nxt_s = dwell_r + DW_ONE;
            end
         end
         default: begin
            state_nxt_s = RD_MANUAL;
            dwell_nxt_s = '0;
            rd_ch_nxt_s = '0;
         end
      endcase
   end

   // Readout FSM registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= RD_MANUAL;
         dwell_r <= '0;
         rd_ch   <= '0;
      end else begin
         state_r <= state_nxt_s;
         dwell_r <= dwell_nxt_s;
         rd_ch   <= rd_ch_nxt_s;
      end
   end

   // Shadow select; a channel index beyond the bank reads as zero.
   always_comb begin
      rd_sel_s = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (rd_ch == SEL_W'(i)) begin
            rd_sel_s = shadow_s[i];
         end else begin
            rd_sel_s = rd_sel_s;
         end
      end
   end

   // Registered readout data, one cycle behind rd_ch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
      end else begin
         rd_data <= rd_sel_s;
      end
   end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank: directed scenarios followed by
// randomized traffic, all compared against an arithmetic reference model.
module tb_perf_counter_bank;
   import perf_cnt_pkg::*;

   localparam int NUM_CH = 6;
   localparam int CNT_W  = 4;
   localparam int DWELL  = 2;
   localparam int SEL_W  = clog2_min1(NUM_CH);
   localparam int MAXV   = (1 << CNT_W) - 1;
   localparam int SEL_N  = 1 << SEL_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic [NUM_CH-1:0] evt;
   logic [NUM_CH-1:0] ch_mask;
   logic              clr;
   logic              snap;
   logic              auto_rot;
   logic [SEL_W-1:0]  sel;
   logic [SEL_W-1:0]  rd_ch;
   logic [CNT_W-1:0]  rd_data;
   logic [NUM_CH-1:0] ovf;

   int total = 0;
   int bad   = 0;

   // reference model state
   int m_cnt [NUM_CH];
   int m_shd [NUM_CH];
   bit m_ovf [NUM_CH];
   bit m_auto;
   int m_dwell;
   int m_rd_ch;
   int m_rd_data;

   perf_counter_bank #(
      .NUM_CH (NUM_CH),
      .CNT_W  (CNT_W),
      .DWELL  (DWELL)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .evt      (evt),
      .ch_mask  (ch_mask),
      .clr      (clr),
      .snap     (snap),
      .auto_rot (auto_rot),
      .sel      (sel),
      .rd_ch    (rd_ch),
      .rd_data  (rd_data),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NUM_CH; i++) begin
         m_cnt[i] = 0;
         m_shd[i] = 0;
         m_ovf[i] = 1'b0;
      end
      m_auto    = 1'b0;
      m_dwell   = 0;
      m_rd_ch   = 0;
      m_rd_data = 0;
   endtask

   task automatic check_outputs();
      logic [NUM_CH-1:0] exp_ovf;
      for (int i = 0; i < NUM_CH; i++) exp_ovf[i] = m_ovf[i];
      check_eq("rd_ch", rd_ch, m_rd_ch);
      check_eq("rd_data", rd_data, m_rd_data);
      check_eq("ovf", ovf, exp_ovf);
   endtask

   // One clock: advance the model from the current inputs, then compare.
   task automatic step();
      int n_cnt [NUM_CH];
      int n_shd [NUM_CH];
      bit n_ovf [NUM_CH];
      int n_rd_data;
      n_rd_data = (m_rd_ch < NUM_CH) ? m_shd[m_rd_ch] : 0;
      for (int i = 0; i < NUM_CH; i++) begin
         n_shd[i] = snap ? m_cnt[i] : m_shd[i];
         n_cnt[i] = m_cnt[i];
         n_ovf[i] = m_ovf[i];
         if (clr) begin
            n_cnt[i] = 0;
            n_ovf[i] = 1'b0;
         end else if (en && ch_mask[i] && evt[i]) begin
            if (m_cnt[i] == MAXV) begin
               n_ovf[i] = 1'b1;
`ifdef PERF_CNT_SAT_EN
               n_cnt[i] = MAXV;
`else
               n_cnt[i] = 0;
`endif
            end else begin
               n_cnt[i] = m_cnt[i] + 1;
            end
         end
      end
      if (!m_auto) begin
         if (auto_rot) begin
            m_auto  = 1'b1;
            m_dwell = 0;
         end else begin
            m_rd_ch = int'(sel);
         end
      end else begin
         if (!auto_rot) begin
            m_auto  = 1'b0;
            m_rd_ch = int'(sel);
            m_dwell = 0;
         end else if (m_dwell == DWELL - 1) begin
            m_dwell = 0;
            m_rd_ch = (m_rd_ch == NUM_CH - 1) ? 0 : (m_rd_ch + 1) % SEL_N;
         end else begin
            m_dwell++;
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_CH; i++) begin
         m_cnt[i] = n_cnt[i];
         m_shd[i] = n_shd[i];
         m_ovf[i] = n_ovf[i];
      end
      m_rd_data = n_rd_data;
      check_outputs();
   endtask

   task automatic idle_inputs();
      en       = 1'b1;
      evt      = '0;
      ch_mask  = '1;
      clr      = 1'b0;
      snap     = 1'b0;
   endtask

   // Assert reset away from the clock edge and check outputs drop at once.
   task automatic do_reset();
      rst = 1'b1;
      #2;
      check_eq("rst_rd_ch", rd_ch, 0);
      check_eq("rst_rd_data", rd_data, 0);
      check_eq("rst_ovf", ovf, 0);
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_hold_data", rd_data, 0);
      model_clear();
      rst = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      auto_rot = 1'b0;
      sel      = '0;
      idle_inputs();
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // count mid-way, then reset mid-count
      evt = 6'b111111;
      repeat (3) step();
      evt = '0;
      snap = 1'b1;
      step();
      snap = 1'b0;
      do_reset();

      // five events on channel 0, snapshot, read channel 0
      sel = '0;
      evt = 6'b000001;
      repeat (5) step();
      evt  = '0;
      snap = 1'b1;
      step();
      snap = 1'b0;
      step();
      check_eq("rd5", rd_data, 5);

      // gated events on channel 2 never count
      en  = 1'b0;
      evt = 6'b000100;
      repeat (10) step();
      en      = 1'b1;
      ch_mask = 6'b111011;
      repeat (10) step();
      ch_mask = '1;
      evt     = '0;
      snap    = 1'b1;
      sel     = 3'd2;
      step();
      snap = 1'b0;
      repeat (2) step();
      check_eq("gated_ch2", rd_data, 0);

      // 17 events on channel 1 of a 4-bit counter
      clr = 1'b1;
      step();
      clr = 1'b0;
      evt = 6'b000010;
      repeat (17) step();
      evt  = '0;
      snap = 1'b1;
      sel  = 3'd1;
      step();
      snap = 1'b0;
      repeat (2) step();
`ifdef PERF_CNT_SAT_EN
      check_eq("ovf_cnt_sat", rd_data, 15);
`else
      check_eq("ovf_cnt_wrap", rd_data, 1);
`endif
      check_eq("ovf1_set", ovf[1], 1);
      clr = 1'b1;
      step();
      clr  = 1'b0;
      snap = 1'b1;
      step();
      snap = 1'b0;
      repeat (2) step();
      check_eq("clr_cnt1", rd_data, 0);
      check_eq("clr_ovf1", ovf[1], 0);

      // clr and snap together keep the old value in the shadow
      sel = 3'd3;
      evt = 6'b001000;
      repeat (7) step();
      evt  = '0;
      clr  = 1'b1;
      snap = 1'b1;
      step();
      clr  = 1'b0;
      snap = 1'b0;
      repeat (2) step();
      check_eq("clrsnap_shadow", rd_data, 7);
      snap = 1'b1;
      step();
      snap = 1'b0;
      repeat (2) step();
      check_eq("clrsnap_next", rd_data, 0);

      // auto rotation, then back to manual
      sel = '0;
      step();
      auto_rot = 1'b1;
      for (int k = 0; k < 14; k++) begin
         step();
         check_eq("rot_seq", rd_ch, (k / 2) % NUM_CH);
      end
      auto_rot = 1'b0;
      sel      = 3'd2;
      step();
      check_eq("rot_exit", rd_ch, 2);

      // out-of-range manual select
      sel = 3'd7;
      repeat (2) step();
      check_eq("sel_oor_ch", rd_ch, 7);
      check_eq("sel_oor_data", rd_data, 0);

      // randomized traffic with a reset in the middle
      for (int c = 0; c < 3000; c++) begin
         en      = ($urandom_range(0, 9) != 0);
         evt     = NUM_CH'($urandom);
         ch_mask = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '1;
         clr     = ($urandom_range(0, 149) == 0);
         snap    = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 24) == 0) auto_rot = ~auto_rot;
         sel     = SEL_W'($urandom);
         if (c == 1500) do_reset();
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
